// File: rtl/branch_resolve_ctrl.sv
// -----------------------------------------------------------------------------
// branch_resolve_ctrl
//   Execute-stage sequencer for conditional branches and jumps. It takes one
//   op at a time from decode, spends one cycle evaluating the condition and
//   the target, and checks the outcome against the fetch prediction. On a
//   mispredict it holds a redirect to fetch until fetch accepts it. A
//   saturating counter tracks accepted redirects for performance monitoring.
//
// Ports
//   clk, rst_n          core clock (rising edge), async active-low reset
//   flush               synchronous abort of any in-flight op (highest priority)
//   req_*               branch op from decode (valid/ready handshake)
//   resolve_*           one-cycle outcome pulse, driven during evaluation
//   redirect_*          corrected fetch PC (valid/ready handshake)
//   clear_count         synchronous clear of mispredict_count
//   mispredict_count    saturating count of accepted redirects
// -----------------------------------------------------------------------------
module branch_resolve_ctrl #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [2:0]       req_type,
  input  logic [XLEN-1:0]  req_rs1,
  input  logic [XLEN-1:0]  req_rs2,
  input  logic [XLEN-1:0]  req_pc,
  input  logic [XLEN-1:0]  req_imm,
  input  logic             req_is_jalr,
  input  logic             req_pred_taken,
  output logic             resolve_valid,
  output logic             resolve_taken,
  output logic             resolve_mispredict,
  output logic             redirect_valid,
  input  logic             redirect_ready,
  output logic [XLEN-1:0]  redirect_pc,
  input  logic             clear_count,
  output logic [CNT_W-1:0] mispredict_count
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    EVAL     = 2'd1,
    REDIRECT = 2'd2
  } state_t;

  typedef enum logic [2:0] {
    BR_EQ     = 3'd0,
    BR_NE     = 3'd1,
    BR_LT     = 3'd2,
    BR_GE     = 3'd3,
    BR_LTU    = 3'd4,
    BR_GEU    = 3'd5,
    BR_ALWAYS = 3'd6,
    BR_NEVER  = 3'd7
  } br_type_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t          state, state_next;

  // Captured copy of the op; req_* may change freely once accepted.
  br_type_t        type_q;
  logic [XLEN-1:0] rs1_q, rs2_q, pc_q, imm_q;
  logic            is_jalr_q, pred_q;

  logic [XLEN-1:0] redirect_pc_q;
  logic [CNT_W-1:0] count_q;

  logic            accept;
  logic            redirect_fire;
  logic            mispredict;

  logic [XLEN:0]   diff;
  logic            n_flag, v_flag;
  logic            eq, lt, ltu;
  logic            taken;
  logic [XLEN-1:0] jalr_sum;
  logic [XLEN-1:0] target;
  logic [XLEN-1:0] fall_through;

  // ---------------------------------------------------------------------------
  // Condition and target evaluation (from the captured operands only)
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal assigned in this block gets a default first, so no
    // path through the case can leave one unassigned and infer a latch.
    taken  = 1'b0;
    diff   = {1'b0, rs1_q} - {1'b0, rs2_q};
    eq     = (diff[XLEN-1:0] == '0);
    n_flag = diff[XLEN-1];
    // Signed overflow of rs1 - rs2: operands of different sign whose
    // difference takes the sign of rs2.
    v_flag = (n_flag & ~rs1_q[XLEN-1] & rs2_q[XLEN-1]) |
             (~n_flag & rs1_q[XLEN-1] & ~rs2_q[XLEN-1]);
    lt     = n_flag ^ v_flag;
    // Borrow out of the zero-extended subtraction means rs1 < rs2 unsigned.
    ltu    = diff[XLEN];

    case (type_q)
      BR_EQ:     taken = eq;
      BR_NE:     taken = ~eq;
      BR_LT:     taken = lt;
      BR_GE:     taken = ~lt;
      BR_LTU:    taken = ltu;
      BR_GEU:    taken = ~ltu;
      BR_ALWAYS: taken = 1'b1;
      BR_NEVER:  taken = 1'b0;
      default:   taken = 1'b0;
    endcase

    jalr_sum     = rs1_q + imm_q;
    target       = is_jalr_q ? {jalr_sum[XLEN-1:1], 1'b0} : (pc_q + imm_q);
    fall_through = pc_q + XLEN'(4);
  end

  assign mispredict    = taken ^ pred_q;
  assign accept        = (state == IDLE) && req_valid && !flush;
  assign redirect_fire = (state == REDIRECT) && redirect_ready && !flush;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: state is updated with non-blocking assignments so every flop
    // samples pre-edge values regardless of block evaluation order.
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic (flush overrides everything)
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next = state;
    if (flush) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE:     if (req_valid)      state_next = EVAL;
        EVAL:     state_next = mispredict ? REDIRECT : IDLE;
        REDIRECT: if (redirect_ready) state_next = IDLE;
        default:  state_next = IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    req_ready          = (state == IDLE);
    resolve_valid      = (state == EVAL) && !flush;
    resolve_taken      = resolve_valid & taken;
    resolve_mispredict = resolve_valid & mispredict;
    redirect_valid     = (state == REDIRECT);
    redirect_pc        = redirect_pc_q;
    mispredict_count   = count_q;
  end

  // ---------------------------------------------------------------------------
  // Operand capture
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      type_q    <= BR_EQ;
      rs1_q     <= '0;
      rs2_q     <= '0;
      pc_q      <= '0;
      imm_q     <= '0;
      is_jalr_q <= 1'b0;
      pred_q    <= 1'b0;
    end else if (accept) begin
      type_q    <= br_type_t'(req_type);
      rs1_q     <= req_rs1;
      rs2_q     <= req_rs2;
      pc_q      <= req_pc;
      imm_q     <= req_imm;
      is_jalr_q <= req_is_jalr;
      pred_q    <= req_pred_taken;
    end
  end

  // ---------------------------------------------------------------------------
  // Redirect PC: loaded once at the end of evaluation, then held until the
  // redirect handshake so fetch always sees a stable value.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      redirect_pc_q <= '0;
    end else if ((state == EVAL) && !flush && mispredict) begin
      redirect_pc_q <= taken ? target : fall_through;
    end
  end

  // ---------------------------------------------------------------------------
  // Saturating mispredict counter; clear wins over a same-cycle increment.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (clear_count) begin
      count_q <= '0;
    end else if (redirect_fire && (count_q != CNT_MAX)) begin
      count_q <= count_q + 1'b1;
    end
  end

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// -----------------------------------------------------------------------------
// tb_branch_resolve_ctrl
//   Directed bench for branch_resolve_ctrl. Two instances share all inputs:
//   dut (CNT_W=16) and dut_sat (CNT_W=2) for counter saturation. Inputs are
//   driven on the falling edge and outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_branch_resolve_ctrl;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        req_valid;
  logic [2:0]  req_type;
  logic [31:0] req_rs1, req_rs2, req_pc, req_imm;
  logic        req_is_jalr;
  logic        req_pred_taken;
  logic        redirect_ready;
  logic        clear_count;

  logic        req_ready, resolve_valid, resolve_taken, resolve_mispredict;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [15:0] mispredict_count;

  logic        req_ready_s, resolve_valid_s, resolve_taken_s, resolve_mispredict_s;
  logic        redirect_valid_s;
  logic [31:0] redirect_pc_s;
  logic [1:0]  mispredict_count_s;

  int checks   = 0;
  int failures = 0;

  branch_resolve_ctrl #(.XLEN(32), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .req_valid(req_valid), .req_ready(req_ready), .req_type(req_type),
    .req_rs1(req_rs1), .req_rs2(req_rs2), .req_pc(req_pc), .req_imm(req_imm),
    .req_is_jalr(req_is_jalr), .req_pred_taken(req_pred_taken),
    .resolve_valid(resolve_valid), .resolve_taken(resolve_taken),
    .resolve_mispredict(resolve_mispredict),
    .redirect_valid(redirect_valid), .redirect_ready(redirect_ready),
    .redirect_pc(redirect_pc),
    .clear_count(clear_count), .mispredict_count(mispredict_count)
  );

  branch_resolve_ctrl #(.XLEN(32), .CNT_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .req_valid(req_valid), .req_ready(req_ready_s), .req_type(req_type),
    .req_rs1(req_rs1), .req_rs2(req_rs2), .req_pc(req_pc), .req_imm(req_imm),
    .req_is_jalr(req_is_jalr), .req_pred_taken(req_pred_taken),
    .resolve_valid(resolve_valid_s), .resolve_taken(resolve_taken_s),
    .resolve_mispredict(resolve_mispredict_s),
    .redirect_valid(redirect_valid_s), .redirect_ready(redirect_ready),
    .redirect_pc(redirect_pc_s),
    .clear_count(clear_count), .mispredict_count(mispredict_count_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed,
                       input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic scramble_req();
    req_type    = 3'($urandom_range(0, 7));
    req_rs1     = $urandom;
    req_rs2     = $urandom;
    req_pc      = $urandom;
    req_imm     = $urandom;
    req_is_jalr = 1'($urandom_range(0, 1));
    req_pred_taken = 1'($urandom_range(0, 1));
  endtask

  // Offer one op in IDLE, then check the resolve pulse in the EVAL cycle.
  // Returns at the falling edge inside EVAL with req_valid low.
  task automatic issue(input string tag, input logic [2:0] t,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] pc, input logic [31:0] imm,
                       input logic jalr, input logic pred,
                       input logic exp_taken, input logic exp_mis);
    @(negedge clk);
    check({tag, ".req_ready"}, 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_type = t; req_rs1 = a; req_rs2 = b;
    req_pc = pc; req_imm = imm; req_is_jalr = jalr; req_pred_taken = pred;
    @(negedge clk);
    req_valid = 1'b0;
    scramble_req();
    #1;
    check({tag, ".resolve_valid"}, 32'(resolve_valid), 32'd1);
    check({tag, ".resolve_taken"}, 32'(resolve_taken), 32'(exp_taken));
    check({tag, ".resolve_mispredict"}, 32'(resolve_mispredict), 32'(exp_mis));
    check({tag, ".eval_req_ready"}, 32'(req_ready), 32'd0);
  endtask

  // Called at the falling edge of the first REDIRECT cycle.
  task automatic finish_redirect(input string tag, input logic [31:0] exp_pc,
                                 input logic [15:0] exp_cnt,
                                 input logic [1:0] exp_cnt_s);
    check({tag, ".redirect_valid"}, 32'(redirect_valid), 32'd1);
    check({tag, ".redirect_pc"}, redirect_pc, exp_pc);
    redirect_ready = 1'b1;
    @(negedge clk);
    redirect_ready = 1'b0;
    check({tag, ".redirect_drop"}, 32'(redirect_valid), 32'd0);
    check({tag, ".idle_ready"}, 32'(req_ready), 32'd1);
    check({tag, ".count"}, 32'(mispredict_count), 32'(exp_cnt));
    check({tag, ".count_sat"}, 32'(mispredict_count_s), 32'(exp_cnt_s));
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; req_valid = 1'b0; req_type = '0;
    req_rs1 = '0; req_rs2 = '0; req_pc = '0; req_imm = '0;
    req_is_jalr = 1'b0; req_pred_taken = 1'b0;
    redirect_ready = 1'b0; clear_count = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Reset state
    @(negedge clk);
    check("rst.req_ready", 32'(req_ready), 32'd1);
    check("rst.resolve_valid", 32'(resolve_valid), 32'd0);
    check("rst.redirect_valid", 32'(redirect_valid), 32'd0);
    check("rst.redirect_pc", redirect_pc, 32'h0);
    check("rst.count", 32'(mispredict_count), 32'd0);

    // BEQ 5==5 predicted taken: correct, no redirect
    issue("beq", 3'd0, 32'd5, 32'd5, 32'h100, 32'h20, 1'b0, 1'b1, 1'b1, 1'b0);
    @(negedge clk);
    check("beq.no_redirect", 32'(redirect_valid), 32'd0);
    check("beq.count", 32'(mispredict_count), 32'd0);

    // BLT -1 < 1 signed, predicted not taken: redirect to 0x200-0x10
    issue("blt", 3'd2, 32'hFFFF_FFFF, 32'd1, 32'h200, 32'hFFFF_FFF0,
          1'b0, 1'b0, 1'b1, 1'b1);
    @(negedge clk);
    check("blt.redirect_pc0", redirect_pc, 32'h1F0);
    check("blt.req_ready", 32'(req_ready), 32'd0);
    for (int i = 0; i < 3; i++) begin
      req_valid = 1'b1;
      scramble_req();
      @(negedge clk);
      check("blt.hold_valid", 32'(redirect_valid), 32'd1);
      check("blt.hold_pc", redirect_pc, 32'h1F0);
    end
    req_valid = 1'b0;
    finish_redirect("blt", 32'h1F0, 16'd1, 2'd1);

    // BLTU 0xFFFFFFFF < 1 unsigned is false, predicted taken: fall-through wraps
    issue("bltu", 3'd4, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFC, 32'h40,
          1'b0, 1'b1, 1'b0, 1'b1);
    @(negedge clk);
    finish_redirect("bltu", 32'h0000_0000, 16'd2, 2'd2);

    // JALR (always taken), bit 0 of rs1+imm cleared
    issue("jalr", 3'd6, 32'h1003, 32'h0, 32'h400, 32'h0, 1'b1, 1'b0, 1'b1, 1'b1);
    @(negedge clk);
    finish_redirect("jalr", 32'h1002, 16'd3, 2'd3);

    // Never-taken predicted taken: fall-through; narrow counter saturates
    issue("never", 3'd7, 32'h0, 32'h0, 32'h500, 32'h80, 1'b0, 1'b1, 1'b0, 1'b1);
    @(negedge clk);
    finish_redirect("never", 32'h504, 16'd4, 2'd3);

    // Correct predictions for the remaining compare types
    issue("bne", 3'd1, 32'd3, 32'd4, 32'h580, 32'h8, 1'b0, 1'b1, 1'b1, 1'b0);
    issue("bge_ovf", 3'd3, 32'h8000_0000, 32'h7FFF_FFFF, 32'h5C0, 32'h8,
          1'b0, 1'b0, 1'b0, 1'b0);
    issue("bgeu", 3'd5, 32'h8000_0000, 32'h7FFF_FFFF, 32'h5E0, 32'h8,
          1'b0, 1'b1, 1'b1, 1'b0);
    @(negedge clk);
    check("bgeu.no_redirect", 32'(redirect_valid), 32'd0);

    // Flush in REDIRECT with a same-cycle handshake: no count
    issue("fl_rd", 3'd0, 32'd1, 32'd2, 32'h600, 32'h10, 1'b0, 1'b1, 1'b0, 1'b1);
    @(negedge clk);
    check("fl_rd.redirect_valid", 32'(redirect_valid), 32'd1);
    flush = 1'b1; redirect_ready = 1'b1;
    @(negedge clk);
    flush = 1'b0; redirect_ready = 1'b0;
    check("fl_rd.redirect_drop", 32'(redirect_valid), 32'd0);
    check("fl_rd.req_ready", 32'(req_ready), 32'd1);
    check("fl_rd.count", 32'(mispredict_count), 32'd4);
    check("fl_rd.count_sat", 32'(mispredict_count_s), 32'd3);

    // Flush with req_valid in IDLE: nothing captured
    req_valid = 1'b1; req_type = 3'd6; req_pred_taken = 1'b0; flush = 1'b1;
    @(negedge clk);
    req_valid = 1'b0; flush = 1'b0;
    check("fl_idle.resolve_valid", 32'(resolve_valid), 32'd0);
    check("fl_idle.req_ready", 32'(req_ready), 32'd1);

    // Flush during EVAL: resolve suppressed, no redirect
    req_valid = 1'b1; req_type = 3'd6; req_pc = 32'h680; req_imm = 32'h4;
    req_is_jalr = 1'b0; req_pred_taken = 1'b0;
    @(negedge clk);
    req_valid = 1'b0; flush = 1'b1;
    #1;
    check("fl_eval.resolve_valid", 32'(resolve_valid), 32'd0);
    @(negedge clk);
    flush = 1'b0;
    check("fl_eval.redirect_valid", 32'(redirect_valid), 32'd0);
    check("fl_eval.req_ready", 32'(req_ready), 32'd1);

    // Async reset in the middle of REDIRECT
    issue("rst_rd", 3'd6, 32'h0, 32'h0, 32'h700, 32'h10, 1'b0, 1'b0, 1'b1, 1'b1);
    @(negedge clk);
    check("rst_rd.redirect_pc", redirect_pc, 32'h710);
    #2 rst_n = 1'b0;
    #1;
    check("rst_rd.redirect_valid", 32'(redirect_valid), 32'd0);
    check("rst_rd.count", 32'(mispredict_count), 32'd0);
    check("rst_rd.count_sat", 32'(mispredict_count_s), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    check("rst_rd.pc_cleared", redirect_pc, 32'h0);

    // Clear coincident with a redirect handshake: result 0
    issue("pre_clr", 3'd1, 32'd9, 32'd9, 32'h800, 32'h20, 1'b0, 1'b1, 1'b0, 1'b1);
    @(negedge clk);
    finish_redirect("pre_clr", 32'h804, 16'd1, 2'd1);
    issue("clr", 3'd3, 32'd2, 32'd1, 32'h900, 32'h8, 1'b0, 1'b0, 1'b1, 1'b1);
    @(negedge clk);
    check("clr.redirect_pc", redirect_pc, 32'h908);
    redirect_ready = 1'b1; clear_count = 1'b1;
    @(negedge clk);
    redirect_ready = 1'b0; clear_count = 1'b0;
    check("clr.count", 32'(mispredict_count), 32'd0);
    check("clr.count_sat", 32'(mispredict_count_s), 32'd0);
    check("clr.redirect_drop", 32'(redirect_valid), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/branch_resolve_ctrl.md
Name: branch_resolve_ctrl

Overview:
Sequencer for conditional branch and jump resolution in the core's execute path. It accepts one branch op at a time from decode over a valid/ready handshake and registers the operands. It evaluates the condition with the team's 3-bit branch-type encoding, compares the outcome against the fetch-time prediction, and issues a held redirect to fetch on a mispredict. It also keeps a saturating mispredict counter for performance monitoring.

Parameters:
XLEN, 32, operand, PC and immediate width
CNT_W, 16, mispredict counter width

Ports:
clk  input  1  core clock, rising edge
rst_n  input  1  asynchronous active-low reset
flush  input  1  trap/pipeline flush; aborts any in-flight op
req_valid  input  1  branch op offered by decode
req_ready  output  1  controller can accept an op
req_type  input  3  0 EQ, 1 NE, 2 LT signed, 3 GE signed, 4 LTU, 5 GEU, 6 always, 7 never
req_rs1  input  XLEN  operand 1
req_rs2  input  XLEN  operand 2
req_pc  input  XLEN  PC of the branch
req_imm  input  XLEN  sign-extended offset
req_is_jalr  input  1  target = rs1+imm with bit 0 cleared
req_pred_taken  input  1  fetch prediction
resolve_valid  output  1  one-cycle pulse when outcome is known
resolve_taken  output  1  actual outcome; valid with resolve_valid
resolve_mispredict  output  1  outcome differs from prediction; valid with resolve_valid
redirect_valid  output  1  corrected PC offered to fetch
redirect_ready  input  1  fetch accepts redirect
redirect_pc  output  XLEN  corrected fetch PC
clear_count  input  1  synchronous counter clear
mispredict_count  output  CNT_W  saturating mispredict count

Behaviour:
- Reset (async, rst_n=0): state IDLE, all captured registers 0, redirect_pc 0, mispredict_count 0, resolve_* 0, redirect_valid 0. req_ready goes to 1 once reset is released.
- States: IDLE, EVAL, REDIRECT.
- IDLE:
  - req_ready=1.
  - req_valid=1 captures all req_* fields on the edge; next state is EVAL.
- EVAL (exactly 1 cycle, req_ready=0):
  - Compute diff = {1'b0,rs1} - {1'b0,rs2} (XLEN+1 bits).
  - EQ: diff[XLEN-1:0]==0. NE: its inverse.
  - LT: N^V, where N=diff[XLEN-1] and V=(N&~rs1[msb]&rs2[msb])|(~N&rs1[msb]&~rs2[msb]). GE: its inverse.
  - LTU: diff[XLEN]. GEU: its inverse.
  - Type 6 is always taken; type 7 is never taken.
  - Drive resolve_valid=1, resolve_taken, and resolve_mispredict = taken ^ pred_taken.
  - Target = is_jalr ? (rs1+imm)&~1 : pc+imm. Fall-through = pc+4. All sums wrap modulo 2^XLEN.
  - Mispredict: register redirect_pc = taken ? target : fall-through, then go to REDIRECT. Otherwise go to IDLE.
- REDIRECT:
  - redirect_valid=1; redirect_pc is held stable until handshake. req_ready=0.
  - On redirect_valid & redirect_ready: count increments, next state is IDLE.
- Latency: accept at edge N, resolve_valid during cycle N+1, redirect_valid from cycle N+2. Back-to-back correct predictions give one op per 2 cycles.
- Counter:
  - Increments on redirect handshake and saturates at 2^CNT_W-1.
  - clear_count has priority over a same-cycle increment (result is 0).
- flush (synchronous, highest priority):
  - Any state goes to IDLE next cycle.
  - In IDLE, a same-cycle req_valid is not captured.
  - In EVAL, resolve_valid is suppressed (forced 0).
  - In REDIRECT, redirect_valid is dropped; a same-cycle handshake does not count.
- req_* may change freely while req_ready=0; only the captured copy is used.
- Reset mid-REDIRECT: redirect_valid drops immediately (async) and the count returns to 0.

Test Plan:
- BEQ rs1=5, rs2=5, pred=1, pc=0x100, imm=0x20 -> resolve_taken=1, mispredict=0, no redirect_valid, count stays 0.
- BLT rs1=0xFFFFFFFF, rs2=1, pred=0 -> taken=1, mispredict=1. With pc=0x200, imm=0xFFFFFFF0, redirect_pc=0x1F0. Hold redirect_ready=0 for 3 cycles: redirect_pc stays stable. Then ready=1 -> count=1.
- BLTU same operands, pred=1, pc=0xFFFFFFFC -> taken=0, redirect_pc=0x00000000 (wrap).
- JALR (type 6) rs1=0x1003, imm=0, pred=0 -> redirect_pc=0x1002.
- flush asserted in REDIRECT together with redirect_ready=1 -> back to IDLE, count unchanged. flush with req_valid in IDLE -> no capture.
- CNT_W=2: four mispredicts -> count saturates at 3. clear_count coincident with a handshake -> count=0.
